// File: rtl/connect_echo_fifo_pkg.sv
// Shared constants for the Connect echo FIFO block and its storage.
// Holds the transform-mode encodings, the rule count and pointer sizing helpers.
// No logic lives here.
package connect_echo_fifo_pkg;

    localparam int MODE_ECHO     = 0;
    localparam int MODE_INCR     = 1;
    localparam int RULE_COUNT    = 1;
    localparam int DEFAULT_DEPTH = 4;
    localparam int PTR_W         = $clog2(DEFAULT_DEPTH);

    // Pointer width for an arbitrary power-of-two depth; occupancy needs one more bit.
    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/connect_echo_fifo_store.sv
// DEPTH x W register-array FIFO with wrapping pointers and an occupancy count.
// Latency: a push at edge t is visible on head_dat from cycle t+1; no bypass.
// Backpressure: push ignored when full, pop ignored when empty; no full-bypass.
module connect_fifo_store
    import connect_echo_fifo_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 2
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   push,
    input  logic [W-1:0]           push_dat,
    input  logic                   pop,
    output logic [W-1:0]           head_dat,
    output logic [ptr_w(DEPTH):0]  occupancy,
    output logic                   full,
    output logic                   empty
);

    localparam int PW = ptr_w(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (occupancy == (PW+1)'(DEPTH));
    assign empty    = (occupancy == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign head_dat = mem[rd_ptr];

    // Payload storage is deliberately left unreset; only pointers/count define validity.
    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally at DEPTH; count moves only when exactly one side fires.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   occupancy <= occupancy + (PW+1)'(1);
                2'b01:   occupancy <= occupancy - (PW+1)'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

endmodule

// File: rtl/connect_echo_fifo.sv
// Connect echo block: queues say(meth, v) requests and replays them on ind_heard.
// Latency: one cycle from say acceptance to earliest indication; no bypass.
// Backpressure: say__RDY drops when full; respond fires only with rule_enable and ind_heard__RDY.
module connect_echo_fifo
    import connect_echo_fifo_pkg::*;
#(
    parameter int DATA_W = 192,
    parameter int DEPTH  = 4,
    parameter int MODE   = 0,
    parameter int CNT_W  = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   say__ENA,
    input  logic [DATA_W-1:0]      say_meth,
    input  logic [DATA_W-1:0]      say_v,
    output logic                   say__RDY,
    output logic                   ind_heard__ENA,
    output logic [DATA_W-1:0]      ind_heard_heard_meth,
    output logic [DATA_W-1:0]      ind_heard_heard_v,
    input  logic                   ind_heard__RDY,
    input  logic [RULE_COUNT-1:0]  rule_enable,
    output logic [RULE_COUNT-1:0]  rule_ready,
    output logic [ptr_w(DEPTH):0]  occupancy,
    output logic [CNT_W-1:0]       say_count,
    output logic [CNT_W-1:0]       heard_count
);

    logic                  say_fire;
    logic                  respond_rdy;
    logic                  respond_fire;
    logic                  full;
    logic                  empty;
    logic [2*DATA_W-1:0]   head_dat;
    logic [DATA_W-1:0]     head_meth;
    logic [DATA_W-1:0]     head_v;

    assign say__RDY     = ~full;
    assign say_fire     = say__ENA & say__RDY;
    assign respond_rdy  = ~empty & ind_heard__RDY;
    assign respond_fire = rule_enable[0] & respond_rdy;

    assign rule_ready[0]  = respond_rdy;
    assign ind_heard__ENA = respond_fire;

    assign head_meth = head_dat[2*DATA_W-1:DATA_W];
    assign head_v    = head_dat[DATA_W-1:0];

    // Transform applies to v only; the increment truncates so all-ones wraps to zero.
    assign ind_heard_heard_meth = head_meth;
    assign ind_heard_heard_v    = (MODE == MODE_INCR) ? head_v + DATA_W'(1) : head_v;

    connect_fifo_store #(
        .DEPTH (DEPTH),
        .W     (2 * DATA_W)
    ) u_store (
        .CLK       (CLK),
        .RST       (RST),
        .push      (say_fire),
        .push_dat  ({say_meth, say_v}),
        .pop       (respond_fire),
        .head_dat  (head_dat),
        .occupancy (occupancy),
        .full      (full),
        .empty     (empty)
    );

    // Transaction counters wrap silently at 2^CNT_W.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            say_count   <= '0;
            heard_count <= '0;
        end else begin
            if (say_fire)     say_count   <= say_count + CNT_W'(1);
            if (respond_fire) heard_count <= heard_count + CNT_W'(1);
        end
    end

endmodule

// File: doc/connect_echo_fifo.md
Name: connect_echo_fifo

Overview:
Parametrised successor to the single-entry Connect echo block. It accepts `say` requests (meth, v) into a DEPTH-entry FIFO. A scheduler-gated `respond` rule pops the head and emits it on the `ind$heard` indication. Optional transform mode and wrap-around statistics counters are added. It sits between the request-side method port and the indication interface, under the same rule_enable/rule_ready scheduling scheme.

Parameters:
DATA_W, 192, width of each of meth and v payload fields
DEPTH, 4, FIFO entries; power of two, >= 2
MODE, 0, 0 = echo unchanged; 1 = heard_v = v + 1 (mod 2^DATA_W); meth always unchanged
CNT_W, 16, width of statistics counters

Ports:
CLK  input  1  clock, all state on rising edge
RST  input  1  reset, asynchronous, active-high
say__ENA  input  1  enqueue request, honoured only when say__RDY=1
say_meth  input  DATA_W  request meth field
say_v  input  DATA_W  request v field
say__RDY  output  1  FIFO not full
ind$heard__ENA  output  1  indication fire
ind$heard_heard_meth  output  DATA_W  head meth
ind$heard_heard_v  output  DATA_W  head v, after MODE transform
ind$heard__RDY  input  1  downstream can accept indication
rule_enable  input  1  bit0 = scheduler enable for respond rule
rule_ready  output  1  bit0 = respond rule can fire
occupancy  output  clog2(DEPTH)+1  current entry count
say_count  output  CNT_W  accepted say transactions, wraps
heard_count  output  CNT_W  fired indications, wraps

Behaviour:
- Reset (RST=1, async assert; deassert sampled on CLK): rd/wr pointers=0, occupancy=0, say_count=0, heard_count=0. Hence say__RDY=1, rule_ready=0, ind$heard__ENA=0. Payload storage is not reset. Reset mid-operation discards all queued entries immediately; no indication fires while RST=1.
- say_fire = say__ENA & say__RDY; say__RDY = (occupancy != DEPTH).
- respond_rdy = (occupancy != 0) & ind$heard__RDY; rule_ready[0] = respond_rdy.
- ind$heard__ENA = respond_fire = rule_enable[0] & respond_rdy (combinational).
- Head outputs are driven combinationally from the storage entry at rd_ptr. Values while occupancy=0 are don't-care.
- Latency: a request accepted at edge t is visible at the head and can fire from cycle t+1. There is no same-cycle bypass.
- Simultaneous say_fire & respond_fire: both pointers advance, occupancy unchanged. When full, say__RDY=0 even if a pop occurs that cycle; there is no full-bypass.
- Pointers are log2(DEPTH) bits and wrap naturally. occupancy is +1 on push only, -1 on pop only, and unchanged on both or neither.
- say_count += 1 per say_fire; heard_count += 1 per respond_fire. Both wrap modulo 2^CNT_W.
- MODE=1 addition truncates to DATA_W; all-ones wraps to 0.
- Ordering is strict FIFO. No entry is lost or duplicated.
- say__ENA while full is ignored: no state change, say_count unchanged.

Decomposition:
- Shared package: localparam PTR_W = clog2(DEPTH); mode constants MODE_ECHO=0, MODE_INCR=1; RULE_COUNT=1 for this block.
- One sub-module, connect_fifo_store: DEPTH x (2*DATA_W) register array with push/pop, pointers, occupancy, full/empty.
- The top holds the handshake, the MODE transform and the counters.

Test Plan:
- Reset then single say (meth=0x11, v=0x22, MODE=0) with rule_enable=1 and ind$heard__RDY=1 -> ind$heard__ENA=1 exactly one cycle later, meth=0x11, v=0x22; say_count=1, heard_count=1, occupancy back to 0.
- Fill DEPTH=4 with ind$heard__RDY=0, values 1..4 -> say__RDY=0 after the 4th, occupancy=4. A 5th say__ENA is ignored (say_count=4). Release RDY -> heard v sequence 1,2,3,4 in order.
- Full FIFO, respond fires and say__ENA=1 in the same cycle -> say__RDY=0, no enqueue, occupancy=3. Next cycle the say is accepted, occupancy=4.
- Occupancy=2, say and respond both fire every cycle for 10 cycles -> occupancy stays 2, output order preserved, both counters advance by 10.
- MODE=1, say v = all-ones (2^192-1) and v=5 -> heard v = 0 then 6, meth unchanged.
- Assert RST asynchronously with 3 entries queued (mid-cycle) -> immediately occupancy=0, ind$heard__ENA=0, counters=0. After release, the first new say is echoed correctly.
